// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: two-requester arbiter over a master/slave JK register bank (clk, rst, req/op/mask per requester -> gnt, q/q_bar, done, busy; optional parity when JK_BANK_PARITY_EN is defined)
module jk_bank_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [1:0]       op_a,
  input  logic [1:0]       op_b,
  input  logic [WIDTH-1:0] mask_a,
  input  logic [WIDTH-1:0] mask_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             done,
  output logic             busy
`ifdef JK_BANK_PARITY_EN
  ,
  output logic             parity
`endif
);
  typedef enum logic [1:0] {IDLE, MASTER, SLAVE} state_t;
  state_t state, state_nx;
  logic start, pick_b, last_b;
  logic [1:0] op_l;
  logic [WIDTH-1:0] mask_l, m, op_val, m_nx;
  assign start = (state == IDLE) && (req_a || req_b);
  assign pick_b = req_b && (!req_a || !last_b);
  assign busy = state != IDLE;
  assign q_bar = ~q;
  always_comb begin
    state_nx = (state == IDLE) ? ((req_a || req_b) ? MASTER : IDLE) : (state == MASTER) ? SLAVE : IDLE;
    op_val = (op_l == 2'b00) ? q : (op_l == 2'b01) ? '0 : (op_l == 2'b10) ? '1 : ~q;
    m_nx = (mask_l & op_val) | (~mask_l & q);
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
      m <= '0;
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
      done <= 1'b0;
      last_b <= 1'b1;
      op_l <= 2'b00;
      mask_l <= '0;
    end else begin
      gnt_a <= start && !pick_b;
      gnt_b <= start && pick_b;
      done <= state == SLAVE;
      if (start) begin
        op_l <= pick_b ? op_b : op_a;
        mask_l <= pick_b ? mask_b : mask_a;
        last_b <= pick_b;
      end
      if (state == MASTER) m <= m_nx;
      if (state == SLAVE) q <= m;
    end
  end
`ifdef JK_BANK_PARITY_EN
  always_ff @(posedge clk)
    parity <= rst ? 1'b0 : (state == SLAVE) ? ^m : parity;
`endif
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb_jk_bank_arbiter: directed self-checking bench for jk_bank_arbiter
module tb_jk_bank_arbiter;
  logic clk = 1'b0;
  logic rst, req_a, req_b, gnt_a, gnt_b, done, busy;
  logic [1:0] op_a, op_b;
  logic [7:0] mask_a, mask_b, q, q_bar;
`ifdef JK_BANK_PARITY_EN
  logic parity;
`endif
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  jk_bank_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
    .mask_a(mask_a), .mask_b(mask_b), .gnt_a(gnt_a), .gnt_b(gnt_b), .q(q), .q_bar(q_bar),
    .done(done), .busy(busy)
`ifdef JK_BANK_PARITY_EN
    , .parity(parity)
`endif
  );
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_st(input string tag, input logic ga, input logic gb, input logic dn, input logic bs, input logic [7:0] qv);
    chk({tag, "_gnt_a"}, {31'd0, gnt_a}, {31'd0, ga});
    chk({tag, "_gnt_b"}, {31'd0, gnt_b}, {31'd0, gb});
    chk({tag, "_done"}, {31'd0, done}, {31'd0, dn});
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, bs});
    chk({tag, "_q"}, {24'd0, q}, {24'd0, qv});
    chk({tag, "_q_bar"}, {24'd0, q_bar}, {24'd0, ~qv});
  endtask
  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    op_a = 2'b00; op_b = 2'b00; mask_a = 8'h00; mask_b = 8'h00;
    @(negedge clk);
    step();
    chk_st("reset", 0, 0, 0, 0, 8'h00);
`ifdef JK_BANK_PARITY_EN
    chk("reset_parity", {31'd0, parity}, 32'd0);
`endif
    rst = 1'b0; req_a = 1'b1; op_a = 2'b10; mask_a = 8'hF0;
    step();
    chk_st("set_e0", 1, 0, 0, 1, 8'h00);
    req_a = 1'b0; op_a = 2'b01; mask_a = 8'hFF;
    step();
    chk_st("set_e1", 0, 0, 0, 1, 8'h00);
    step();
    chk_st("set_e2", 0, 0, 1, 0, 8'hF0);
    req_b = 1'b1; op_b = 2'b11; mask_b = 8'hFF;
    step();
    chk_st("tog_e0", 0, 1, 0, 1, 8'hF0);
    req_b = 1'b0;
    step();
    chk_st("tog_e1", 0, 0, 0, 1, 8'hF0);
    step();
    chk_st("tog_e2", 0, 0, 1, 0, 8'h0F);
    rst = 1'b1;
    req_a = 1'b1; op_a = 2'b10; mask_a = 8'h01;
    req_b = 1'b1; op_b = 2'b10; mask_b = 8'h80;
    step();
    chk_st("tie_rst", 0, 0, 0, 0, 8'h00);
    rst = 1'b0;
    step();
    chk_st("tie_a_e0", 1, 0, 0, 1, 8'h00);
    req_a = 1'b0;
    step();
    chk_st("tie_a_e1", 0, 0, 0, 1, 8'h00);
    step();
    chk_st("tie_a_e2", 0, 0, 1, 0, 8'h01);
    step();
    chk_st("tie_b_e0", 0, 1, 0, 1, 8'h01);
    req_b = 1'b0;
    step();
    step();
    chk_st("tie_b_e2", 0, 0, 1, 0, 8'h81);
    req_a = 1'b1; op_a = 2'b10; mask_a = 8'hFF;
    step();
    chk_st("abort_e0", 1, 0, 0, 1, 8'h81);
    req_a = 1'b0; rst = 1'b1;
    step();
    chk_st("abort_rst", 0, 0, 0, 0, 8'h00);
    rst = 1'b0;
    step();
    chk_st("abort_after", 0, 0, 0, 0, 8'h00);
    req_a = 1'b1; op_a = 2'b10; mask_a = 8'h3C;
    step();
    req_a = 1'b0;
    step();
    step();
    chk_st("pre3c", 0, 0, 1, 0, 8'h3C);
    req_b = 1'b1; op_b = 2'b00; mask_b = 8'hFF;
    step();
    chk_st("hold_e0", 0, 1, 0, 1, 8'h3C);
    req_b = 1'b0;
    step();
    step();
    chk_st("hold_e2", 0, 0, 1, 0, 8'h3C);
    req_a = 1'b1; op_a = 2'b01; mask_a = 8'h00;
    step();
    chk_st("zmask_e0", 1, 0, 0, 1, 8'h3C);
    req_a = 1'b0;
    step();
    step();
    chk_st("zmask_e2", 0, 0, 1, 0, 8'h3C);
    step();
    chk_st("idle_end", 0, 0, 0, 0, 8'h3C);
`ifdef JK_BANK_PARITY_EN
    rst = 1'b1;
    step();
    rst = 1'b0; req_a = 1'b1; op_a = 2'b10; mask_a = 8'h07;
    step();
    req_a = 1'b0;
    step();
    step();
    chk("par_q07", {24'd0, q}, 32'h07);
    chk("par_07", {31'd0, parity}, 32'd1);
    req_a = 1'b1; op_a = 2'b01; mask_a = 8'h04;
    step();
    req_a = 1'b0;
    step();
    step();
    chk("par_q03", {24'd0, q}, 32'h03);
    chk("par_03", {31'd0, parity}, 32'd0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
